// File: rtl/intc_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
// Holds the FSM state encoding and the handler-address calculation.
package intc_pkg;

  localparam int unsigned VEC_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } intc_state_e;

  // The offset is truncated to VEC_W bits, so vectors wrap modulo 2^16.
  function automatic logic [VEC_W-1:0] calc_vector(input logic [VEC_W-1:0] base,
                                                   input logic [VEC_W-1:0] stride,
                                                   input int unsigned      idx);
    logic [31:0] offset;
    offset = idx * 32'(stride);
    return base + offset[VEC_W-1:0];
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder.
// Used both to pick the winning interrupt and the in-service bit to retire on EOI.
module intc_prio_enc #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IdxW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec_i[i] && !valid_o) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/intc_vectored.sv
// Vectored interrupt controller: latches requests, masks, arbitrates and tracks in-service.
// Define INTC_NESTING_EN to let strictly higher-priority channels preempt a running handler.
module intc_vectored
  import intc_pkg::*;
#(
  parameter  int unsigned        NUM_IRQ       = 3,
  parameter  logic [VEC_W-1:0]   VECTOR_BASE   = 16'h0008,
  parameter  logic [VEC_W-1:0]   VECTOR_STRIDE = 16'h0004,
  parameter  logic [NUM_IRQ-1:0] EDGE_MASK     = '0,
  parameter  logic [NUM_IRQ-1:0] MASK_RESET    = '1,
  localparam int unsigned        IdW           = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_clr,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] mask_rdata,
  output logic [NUM_IRQ-1:0] pending_rdata,
  output logic               irq_req,
  output logic [VEC_W-1:0]   irq_vector,
  output logic [IdW-1:0]     irq_id,
  input  logic               irq_ack,
  input  logic               irq_eoi
);

  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] clr_q, clr_d;
  intc_state_e        state_q, state_d;
  logic               req_q, req_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic [IdW-1:0]     id_q, id_d;

  logic [NUM_IRQ-1:0] blocked, eligible, rise, ack_oh, eoi_oh;
  logic               grant_valid, eoi_valid, ack_fire;
  logic [IdW-1:0]     grant_idx, eoi_idx;

`ifdef INTC_NESTING_EN
  // A channel is blocked by any in-service channel of equal or higher priority.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    blocked = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      acc        = acc | in_service_q[i];
      blocked[i] = acc;
    end
  end
`else
  assign blocked = {NUM_IRQ{|in_service_q}};
`endif

  assign eligible = pending_q & mask_q & ~blocked;

  intc_prio_enc #(
    .WIDTH (NUM_IRQ)
  ) u_arb (
    .vec_i   (eligible),
    .valid_o (grant_valid),
    .idx_o   (grant_idx)
  );

  intc_prio_enc #(
    .WIDTH (NUM_IRQ)
  ) u_eoi (
    .vec_i   (in_service_q),
    .valid_o (eoi_valid),
    .idx_o   (eoi_idx)
  );

  assign ack_fire = (state_q == StReq) && irq_ack;
  assign rise     = irq_in & ~prev_q;

  always_comb begin
    ack_oh = '0;
    eoi_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_oh[i] = ack_fire && (id_q == IdW'(i));
      eoi_oh[i] = irq_eoi && eoi_valid && (eoi_idx == IdW'(i));
    end
  end

  // Edge channels hold until ack (a new edge wins); level channels follow irq_in
  // but are forced low for the ack cycle.
  always_comb begin
    pending_d    = (EDGE_MASK & ((pending_q & ~ack_oh) | rise)) |
                   (~EDGE_MASK & irq_in & ~ack_oh);
    in_service_d = (in_service_q & ~eoi_oh) | ack_oh;
    mask_d       = mask_we ? mask_wdata : mask_q;
    clr_d        = ack_oh;
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    vector_d = vector_q;
    id_d     = id_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d  = StReq;
          req_d    = 1'b1;
          vector_d = calc_vector(VECTOR_BASE, VECTOR_STRIDE, 32'(grant_idx));
          id_d     = grant_idx;
        end
      end
      StReq: begin
        if (irq_ack) begin
          state_d = StHold;
          req_d   = 1'b0;
        end else if (grant_valid) begin
          vector_d = calc_vector(VECTOR_BASE, VECTOR_STRIDE, 32'(grant_idx));
          id_d     = grant_idx;
        end else begin
          state_d = StIdle;
          req_d   = 1'b0;
        end
      end
      StHold: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= MASK_RESET;
      prev_q       <= '0;
      clr_q        <= '0;
      state_q      <= StIdle;
      req_q        <= 1'b0;
      vector_q     <= VECTOR_BASE;
      id_q         <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
      prev_q       <= irq_in;
      clr_q        <= clr_d;
      state_q      <= state_d;
      req_q        <= req_d;
      vector_q     <= vector_d;
      id_q         <= id_d;
    end
  end

  assign irq_clr       = clr_q;
  assign mask_rdata    = mask_q;
  assign pending_rdata = pending_q;
  assign irq_req       = req_q;
  assign irq_vector    = vector_q;
  assign irq_id        = id_q;

endmodule

// File: tb/tb_intc_vectored.sv
// Directed bench for intc_vectored: per-cycle vector table plus a latency/clear-pulse sequence.
// A second instance with a high VECTOR_BASE checks 16-bit vector wrap-around.
module tb_intc_vectored;

  typedef struct {
    logic        rst;
    logic [2:0]  irq;
    logic        we;
    logic [2:0]  wd;
    logic        ack;
    logic        eoi;
    logic [2:0]  pend;
    logic        req;
    logic [15:0] vec;
    logic [1:0]  id;
    logic [2:0]  clr;
    logic [2:0]  mask;
  } vec_t;

`ifdef INTC_NESTING_EN
  localparam bit Nest = 1'b1;
`else
  localparam bit Nest = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  irq_in = 3'b000;
  logic        mask_we = 1'b0;
  logic [2:0]  mask_wdata = 3'b000;
  logic        irq_ack = 1'b0;
  logic        irq_eoi = 1'b0;

  logic [2:0]  irq_clr, mask_rdata, pending_rdata;
  logic        irq_req;
  logic [15:0] irq_vector;
  logic [1:0]  irq_id;

  logic [2:0]  w_clr, w_mask, w_pend;
  logic        w_req;
  logic [15:0] w_vec;
  logic [1:0]  w_id;

  int   checks = 0;
  int   errors = 0;
  int   cur_row = 0;
  vec_t rows[$];

  intc_vectored #(
    .NUM_IRQ   (3),
    .EDGE_MASK (3'b001)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_in        (irq_in),
    .irq_clr       (irq_clr),
    .mask_we       (mask_we),
    .mask_wdata    (mask_wdata),
    .mask_rdata    (mask_rdata),
    .pending_rdata (pending_rdata),
    .irq_req       (irq_req),
    .irq_vector    (irq_vector),
    .irq_id        (irq_id),
    .irq_ack       (irq_ack),
    .irq_eoi       (irq_eoi)
  );

  intc_vectored #(
    .NUM_IRQ     (3),
    .VECTOR_BASE (16'hFFF8),
    .EDGE_MASK   (3'b001)
  ) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .irq_in        (irq_in),
    .irq_clr       (w_clr),
    .mask_we       (mask_we),
    .mask_wdata    (mask_wdata),
    .mask_rdata    (w_mask),
    .pending_rdata (w_pend),
    .irq_req       (w_req),
    .irq_vector    (w_vec),
    .irq_id        (w_id),
    .irq_ack       (irq_ack),
    .irq_eoi       (irq_eoi)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h, expected %h", name, cur_row, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [2:0] i, input logic w,
                              input logic [2:0] wd, input logic a, input logic e,
                              input logic [2:0] p, input logic q, input logic [15:0] v,
                              input logic [1:0] d, input logic [2:0] c, input logic [2:0] m);
    vec_t t;
    t.rst = r;  t.irq = i; t.we = w;  t.wd = wd; t.ack = a; t.eoi = e;
    t.pend = p; t.req = q; t.vec = v; t.id = d;  t.clr = c; t.mask = m;
    rows.push_back(t);
  endfunction

  initial begin
    int lat;
    //  rst irq    we wd     ack eoi | pend   req vec       id    clr     mask
    // Level channel 1: request, ack, clear pulse, EOI; ack ignored in HOLD and IDLE.
    add(1, 3'b000, 0, 3'b000, 0, 0,  3'b000, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b010, 0, 3'b000, 0, 0,  3'b010, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b010, 0, 3'b000, 0, 0,  3'b010, 1, 16'h000C, 2'd1, 3'b000, 3'b111);
    add(0, 3'b010, 0, 3'b000, 1, 0,  3'b000, 0, 16'h000C, 2'd1, 3'b010, 3'b111);
    add(0, 3'b010, 0, 3'b000, 1, 0,  3'b010, 0, 16'h000C, 2'd1, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b000, 0, 16'h000C, 2'd1, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 1,  3'b000, 0, 16'h000C, 2'd1, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 1, 0,  3'b000, 0, 16'h000C, 2'd1, 3'b000, 3'b111);
    // Edge channel 0: pulse held; ack clears; pulse during ack keeps it pending.
    add(0, 3'b001, 0, 3'b000, 0, 0,  3'b001, 0, 16'h000C, 2'd1, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b001, 1, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 1, 0,  3'b000, 0, 16'h0008, 2'd0, 3'b001, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b000, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 1,  3'b000, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b001, 0, 3'b000, 0, 0,  3'b001, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b001, 1, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b001, 0, 3'b000, 1, 0,  3'b001, 0, 16'h0008, 2'd0, 3'b001, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b001, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 1,  3'b001, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b001, 1, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 1, 0,  3'b000, 0, 16'h0008, 2'd0, 3'b001, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 1,  3'b000, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 1, 0,  3'b000, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    // Mask 3'b011 with 3'b110 requested: ch1 served, masked ch2 never requested.
    add(0, 3'b110, 1, 3'b011, 0, 0,  3'b110, 0, 16'h0008, 2'd0, 3'b000, 3'b011);
    add(0, 3'b110, 0, 3'b000, 0, 0,  3'b110, 1, 16'h000C, 2'd1, 3'b000, 3'b011);
    add(0, 3'b110, 0, 3'b000, 1, 0,  3'b100, 0, 16'h000C, 2'd1, 3'b010, 3'b011);
    add(0, 3'b110, 0, 3'b000, 0, 0,  3'b110, 0, 16'h000C, 2'd1, 3'b000, 3'b011);
    add(0, 3'b100, 0, 3'b000, 0, 1,  3'b100, 0, 16'h000C, 2'd1, 3'b000, 3'b011);
    add(0, 3'b100, 0, 3'b000, 0, 0,  3'b100, 0, 16'h000C, 2'd1, 3'b000, 3'b011);
    add(0, 3'b100, 0, 3'b000, 0, 0,  3'b100, 0, 16'h000C, 2'd1, 3'b000, 3'b011);
    // Unmask; ch2 in REQ is replaced by ch0 before ack.
    add(0, 3'b100, 1, 3'b111, 0, 0,  3'b100, 0, 16'h000C, 2'd1, 3'b000, 3'b111);
    add(0, 3'b100, 0, 3'b000, 0, 0,  3'b100, 1, 16'h0010, 2'd2, 3'b000, 3'b111);
    add(0, 3'b101, 0, 3'b000, 0, 0,  3'b101, 1, 16'h0010, 2'd2, 3'b000, 3'b111);
    add(0, 3'b100, 0, 3'b000, 0, 0,  3'b101, 1, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b100, 0, 3'b000, 1, 0,  3'b100, 0, 16'h0008, 2'd0, 3'b001, 3'b111);
    add(0, 3'b100, 0, 3'b000, 0, 0,  3'b100, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b100, 0, 3'b000, 0, 1,  3'b100, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    // ch2 in service, ch0 arrives: preempts only with nesting.
    add(0, 3'b100, 0, 3'b000, 0, 0,  3'b100, 1, 16'h0010, 2'd2, 3'b000, 3'b111);
    add(0, 3'b100, 0, 3'b000, 1, 0,  3'b000, 0, 16'h0010, 2'd2, 3'b100, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b000, 0, 16'h0010, 2'd2, 3'b000, 3'b111);
    add(0, 3'b001, 0, 3'b000, 0, 0,  3'b001, 0, 16'h0010, 2'd2, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b001, Nest, Nest ? 16'h0008 : 16'h0010,
        Nest ? 2'd0 : 2'd2, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b001, Nest, Nest ? 16'h0008 : 16'h0010,
        Nest ? 2'd0 : 2'd2, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 1,  3'b001, Nest, Nest ? 16'h0008 : 16'h0010,
        Nest ? 2'd0 : 2'd2, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b001, 1, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 1, 0,  3'b000, 0, 16'h0008, 2'd0, 3'b001, 3'b111);
    // Reset with ch0 in service and mask changed; afterwards ch1 is not blocked.
    add(0, 3'b010, 1, 3'b010, 0, 0,  3'b010, 0, 16'h0008, 2'd0, 3'b000, 3'b010);
    add(1, 3'b010, 0, 3'b000, 0, 0,  3'b000, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b010, 0, 3'b000, 0, 0,  3'b010, 0, 16'h0008, 2'd0, 3'b000, 3'b111);
    add(0, 3'b010, 0, 3'b000, 0, 0,  3'b010, 1, 16'h000C, 2'd1, 3'b000, 3'b111);
    // Level drop in REQ returns to IDLE.
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b000, 1, 16'h000C, 2'd1, 3'b000, 3'b111);
    add(0, 3'b000, 0, 3'b000, 0, 0,  3'b000, 0, 16'h000C, 2'd1, 3'b000, 3'b111);
    // Masking the granted channel drops irq_req; pending is kept.
    add(0, 3'b010, 0, 3'b000, 0, 0,  3'b010, 0, 16'h000C, 2'd1, 3'b000, 3'b111);
    add(0, 3'b010, 0, 3'b000, 0, 0,  3'b010, 1, 16'h000C, 2'd1, 3'b000, 3'b111);
    add(0, 3'b010, 1, 3'b000, 0, 0,  3'b010, 1, 16'h000C, 2'd1, 3'b000, 3'b000);
    add(0, 3'b010, 0, 3'b000, 0, 0,  3'b010, 0, 16'h000C, 2'd1, 3'b000, 3'b000);
    add(0, 3'b010, 1, 3'b111, 0, 0,  3'b010, 0, 16'h000C, 2'd1, 3'b000, 3'b111);
    add(0, 3'b010, 0, 3'b000, 0, 0,  3'b010, 1, 16'h000C, 2'd1, 3'b000, 3'b111);

    for (int r = 0; r < rows.size(); r++) begin
      cur_row    = r;
      rst        = rows[r].rst;
      irq_in     = rows[r].irq;
      mask_we    = rows[r].we;
      mask_wdata = rows[r].wd;
      irq_ack    = rows[r].ack;
      irq_eoi    = rows[r].eoi;
      step();
      check("pending", 16'(pending_rdata), 16'(rows[r].pend));
      check("irq_req", 16'(irq_req), 16'(rows[r].req));
      check("irq_vector", irq_vector, rows[r].vec);
      check("irq_id", 16'(irq_id), 16'(rows[r].id));
      check("irq_clr", 16'(irq_clr), 16'(rows[r].clr));
      check("mask", 16'(mask_rdata), 16'(rows[r].mask));
      check("wrap_vector", w_vec, rows[r].vec + 16'hFFF0);
      check("wrap_req", 16'(w_req), 16'(rows[r].req));
    end

    // Input-to-request latency and a single-cycle clear pulse.
    cur_row = -1;
    rst = 1'b1; irq_in = 3'b000; mask_we = 1'b0; irq_ack = 1'b0; irq_eoi = 1'b0;
    step();
    rst = 1'b0;
    step();
    irq_in = 3'b010;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!irq_req && lat < 10);
    check("latency", 16'(lat), 16'd2);
    check("lat_vector", irq_vector, 16'h000C);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("clr_pulse", 16'(irq_clr), 16'(3'b010));
    check("req_low_after_ack", 16'(irq_req), 16'd0);
    step();
    check("clr_single_cycle", 16'(irq_clr), 16'd0);
    check("req_low_in_hold", 16'(irq_req), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
